// File: rtl/fp_pkg.sv
// fp_pkg
//   Types and constants shared by the floating-point multiply and divide units.
//   Contents:
//     XLEN, EXP_W, MAN_W, BIAS : binary32 geometry and exponent bias
//     QNAN, POS_INF            : canonical special encodings
//     fp32_t                   : binary32 field view {sign, exp, man}
//     fmul_state_e             : multiplier sequencing states
package fp_pkg;

    localparam int XLEN  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [XLEN-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [XLEN-1:0] POS_INF = 32'h7F80_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_MUL,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } fmul_state_e;

endpackage

// File: rtl/multiplication_floating_mant_mul_seq.sv
// mant_mul_seq
//   24x24 unsigned shift-add multiplier, one multiplier bit per clock.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     start    : one-cycle pulse; loads a/b and clears the accumulator
//     a, b     : 24-bit mantissas with hidden bit
//     done     : high during the last of the 24 iteration cycles
//     prod     : 48-bit accumulator; final once the cycle after done has passed
module mant_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic        done,
    output logic [47:0] prod
);

    logic [47:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;

    // The multiplicand is shifted left and the multiplier right each step,
    // so no variable shifter is needed.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            mcand_d  = {24'h0, a};
            mplier_d = b;
            acc_d    = 48'h0;
            cnt_d    = 5'd0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[46:0], 1'b0};
            mplier_d = {1'b0, mplier_q[23:1]};
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= 48'h0;
            mplier_q <= 24'h0;
            acc_q    <= 48'h0;
            cnt_q    <= 5'd0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    assign done = run_q && (cnt_q == 5'd23);
    assign prod = acc_q;

endmodule

// File: rtl/multiplication_floating.sv
// multiplication_floating
//   Multi-cycle IEEE-754 binary32 multiplier, round-to-nearest-even,
//   denormals-as-zero on input, flush-to-zero on output. Fixed latency:
//   data_ready pulses 27 edges after the accepting edge.
//   Ports:
//     CLK, rst                 : clock, synchronous active-high reset
//     multiplicand, multiplier : binary32 operands, latched when data_valid in IDLE
//     data_valid               : request strobe, ignored while busy
//     busy_o                   : operation in flight
//     product_o                : result, held until next result or reset
//     invalid_o/overflow_o/underflow_o : result flags, held with product_o
//     data_ready               : one-cycle result-valid pulse
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | waiting for data_valid
//   ST_UNPACK | sign/exponent/class of latched operands, start core
//   ST_MUL    | 24 shift-add iterations in mant_mul_seq
//   ST_NORM   | align product to 1.x, extract guard and sticky
//   ST_ROUND  | RNE, range check, specials, register result and flags
//   ST_DONE   | data_ready high
module multiplication_floating
    import fp_pkg::*;
(
    input  logic            CLK,
    input  logic            rst,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    input  logic            data_valid,
    output logic            busy_o,
    output logic [XLEN-1:0] product_o,
    output logic            invalid_o,
    output logic            overflow_o,
    output logic            underflow_o,
    output logic            data_ready
);

    fmul_state_e state_q, state_d;
    fp32_t       opa_q, opa_d, opb_q, opb_d;
    logic        sign_q, sign_d;
    logic [9:0]  exp_q, exp_d;          // biased exponent, two's complement
    logic        nan_q, nan_d, inf_q, inf_d, zero_q, zero_d;
    logic [23:0] man_q, man_d;
    logic        guard_q, guard_d, sticky_q, sticky_d;
    logic [31:0] product_q, product_d;
    logic        invalid_q, invalid_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic        ready_q, ready_d;

    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        mul_start, mul_done;
    logic [47:0] mul_prod;
    logic        round_up;
    logic [24:0] man_rnd;
    logic [9:0]  exp_rnd;
    logic [22:0] man_fin;

    // Exponent 0 covers true zeros and denormals alike (DAZ).
    assign a_zero = (opa_q.exp == 8'h00);
    assign b_zero = (opb_q.exp == 8'h00);
    assign a_inf  = (opa_q.exp == 8'hFF) && (opa_q.man == 23'h0);
    assign b_inf  = (opb_q.exp == 8'hFF) && (opb_q.man == 23'h0);
    assign a_nan  = (opa_q.exp == 8'hFF) && (opa_q.man != 23'h0);
    assign b_nan  = (opb_q.exp == 8'hFF) && (opb_q.man != 23'h0);

    mant_mul_seq u_mant_mul (
        .clk   (CLK),
        .rst   (rst),
        .start (mul_start),
        .a     ({~a_zero, opa_q.man}),
        .b     ({~b_zero, opb_q.man}),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        round_up = guard_q & (sticky_q | man_q[0]);
        man_rnd  = {1'b0, man_q} + {24'h0, round_up};
        exp_rnd  = man_rnd[24] ? (exp_q + 10'd1) : exp_q;
        // On carry-out the mantissa is 1.000..0, so the stored field is zero either way.
        man_fin  = man_rnd[24] ? man_rnd[23:1] : man_rnd[22:0];
    end

    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        nan_d       = nan_q;
        inf_d       = inf_q;
        zero_d      = zero_q;
        man_d       = man_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        product_d   = product_q;
        invalid_d   = invalid_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        ready_d     = 1'b0;
        mul_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    opa_d   = multiplicand;
                    opb_d   = multiplier;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                sign_d    = opa_q.sign ^ opb_q.sign;
                exp_d     = {2'b00, opa_q.exp} + {2'b00, opb_q.exp} - 10'(BIAS);
                nan_d     = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
                inf_d     = a_inf | b_inf;
                zero_d    = a_zero | b_zero;
                mul_start = 1'b1;
                state_d   = ST_MUL;
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (mul_prod[47]) begin
                    man_d    = mul_prod[47:24];
                    guard_d  = mul_prod[23];
                    sticky_d = |mul_prod[22:0];
                    exp_d    = exp_q + 10'd1;
                end else begin
                    man_d    = mul_prod[46:23];
                    guard_d  = mul_prod[22];
                    sticky_d = |mul_prod[21:0];
                end
                state_d = ST_NORM == ST_NORM ? ST_ROUND : ST_ROUND;
            end
            ST_ROUND: begin
                invalid_d   = 1'b0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
                if (nan_q) begin
                    product_d = QNAN;
                    invalid_d = 1'b1;
                end else if (inf_q) begin
                    product_d = {sign_q, POS_INF[30:0]};
                end else if (zero_q) begin
                    product_d = {sign_q, 31'h0};
                end else if ($signed(exp_rnd) >= $signed(10'd255)) begin
                    product_d  = {sign_q, POS_INF[30:0]};
                    overflow_d = 1'b1;
                end else if ($signed(exp_rnd) <= $signed(10'd0)) begin
                    product_d   = {sign_q, 31'h0};
                    underflow_d = 1'b1;
                end else begin
                    product_d = {sign_q, exp_rnd[7:0], man_fin};
                end
                ready_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            sign_q      <= 1'b0;
            exp_q       <= 10'd0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            man_q       <= 24'h0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            product_q   <= 32'h0;
            invalid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            nan_q       <= nan_d;
            inf_q       <= inf_d;
            zero_q      <= zero_d;
            man_q       <= man_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            product_q   <= product_d;
            invalid_q   <= invalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            ready_q     <= ready_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign product_o   = product_q;
    assign invalid_o   = invalid_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign data_ready  = ready_q;

endmodule

// File: tb/tb_multiplication_floating.sv
// tb_multiplication_floating
//   Directed vectors with hand-computed binary32 results for multiplication_floating.
//   Each operation checks the exact data_ready edge, busy, product and the three flags.
module tb_multiplication_floating;

    logic        CLK = 1'b0;
    logic        rst;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        data_valid;
    logic        busy_o;
    logic [31:0] product_o;
    logic        invalid_o;
    logic        overflow_o;
    logic        underflow_o;
    logic        data_ready;

    int total = 0;
    int bad   = 0;

    multiplication_floating dut (
        .CLK          (CLK),
        .rst          (rst),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .data_valid   (data_valid),
        .busy_o       (busy_o),
        .product_o    (product_o),
        .invalid_o    (invalid_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o),
        .data_ready   (data_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Issue one operation and follow it to edge 28. pulse_a/pulse_b name
    // edges at which a stray data_valid (with different operands) is applied.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want_p, input logic [2:0] want_flags,
                          input int pulse_a, input int pulse_b);
        logic [31:0] rdy_mask;
        logic [31:0] got_p;
        logic [2:0]  got_flags;
        logic        busy_start;
        logic        busy_end;
        got_p     = 32'h0;
        got_flags = 3'b000;
        busy_end  = 1'b1;
        @(negedge CLK);
        multiplicand = a;
        multiplier   = b;
        data_valid   = 1'b1;
        @(posedge CLK);
        #1;
        data_valid = 1'b0;
        busy_start = busy_o;
        rdy_mask   = 32'h0;
        for (int e = 1; e <= 28; e++) begin
            if (e == pulse_a || e == pulse_b) begin
                data_valid   = 1'b1;
                multiplicand = 32'h3F80_0000;
                multiplier   = 32'h4040_0000;
            end
            @(posedge CLK);
            #1;
            data_valid = 1'b0;
            if (data_ready) rdy_mask[e] = 1'b1;
            if (e == 27) begin
                got_p     = product_o;
                got_flags = {invalid_o, overflow_o, underflow_o};
            end
            if (e == 28) busy_end = busy_o;
        end
        chk({tag, ".ready_edge"}, rdy_mask, 32'h0800_0000);
        chk({tag, ".busy"}, {30'h0, busy_start, busy_end}, 32'h2);
        chk({tag, ".product"}, got_p, want_p);
        chk({tag, ".flags_iou"}, {29'h0, got_flags}, {29'h0, want_flags});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        data_valid   = 1'b0;
        multiplicand = 32'h0;
        multiplier   = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset.outputs",
            {27'h0, busy_o, invalid_o, overflow_o, underflow_o, data_ready}, 32'h0);
        chk("reset.product", product_o, 32'h0);
        rst = 1'b0;

        // flags argument order: {invalid, overflow, underflow}
        run_op("mul_3x2",      32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 3'b000, -1, -1);
        run_op("mul_neg",      32'hBFC0_0000, 32'h3E14_0000, 32'hBE5E_0000, 3'b000, -1, -1);
        run_op("rne_sticky",   32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000, -1, -1);
        run_op("tie_odd_up",   32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000, -1, -1);
        run_op("tie_even",     32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 3'b000, -1, -1);
        run_op("max_mant",     32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 3'b000, -1, -1);
        run_op("inf_x_zero",   32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, -1, -1);
        run_op("nan_x_one",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b100, -1, -1);
        run_op("ninf_x_two",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000, -1, -1);
        run_op("nzero_x_3",    32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 3'b000, -1, -1);
        run_op("denorm_daz",   32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 3'b000, -1, -1);
        run_op("underflow",    32'h0D80_0000, 32'h0D80_0000, 32'h0000_0000, 3'b001, -1, -1);
        run_op("ignore_valid", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 3'b000, 5, 15);
        run_op("overflow",     32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b010, -1, -1);

        // Abort an operation with rst on its edge 10.
        @(negedge CLK);
        multiplicand = 32'h4040_0000;
        multiplier   = 32'h4000_0000;
        data_valid   = 1'b1;
        @(posedge CLK);
        #1;
        data_valid = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        rst = 1'b1;
        @(posedge CLK);
        #1;
        rst = 1'b0;
        chk("abort.outputs",
            {27'h0, busy_o, invalid_o, overflow_o, underflow_o, data_ready}, 32'h0);
        chk("abort.product", product_o, 32'h0);
        run_op("after_abort",  32'hBFC0_0000, 32'h3E14_0000, 32'hBE5E_0000, 3'b000, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
